// File: rtl/write_buffer_if.sv
// write_buffer_if
//   Bus bundle for the write-back buffer. It carries the eviction push
//   handshake, the drain port to main memory, the miss-path lookup port and
//   the occupancy status.
//   slave  : the buffer's view. It receives push, mem_ready and lookup, and
//            drives the drain, lookup result and status signals.
//   master : the view of the cache controller / memory side.
interface write_buffer_if #(
    parameter int unsigned BLOCK_SIZE = 256,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [BLOCK_SIZE-1:0] in_block;
    logic                  in_ready;
    logic                  mem_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_w_addr;
    logic [BLOCK_SIZE-1:0] mem_block;
    logic [ADDR_WIDTH-1:0] lk_addr;
    logic                  lk_hit;
    logic [BLOCK_SIZE-1:0] lk_block;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;

    modport slave (
        input  in_valid, in_addr, in_block, mem_ready, lk_addr,
        output in_ready, mem_we, mem_w_addr, mem_block, lk_hit, lk_block,
               full, empty, count
    );

    modport master (
        output in_valid, in_addr, in_block, mem_ready, lk_addr,
        input  in_ready, mem_we, mem_w_addr, mem_block, lk_hit, lk_block,
               full, empty, count
    );
endinterface

// File: rtl/write_buffer.sv
// write_buffer
//   Write-back buffer between the cache controller and main memory. It holds
//   up to DEPTH evicted dirty blocks in a circular FIFO. Repeat writes to an
//   address that is already pending are coalesced in place. Entries drain in
//   FIFO order to the memory write port.
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset; discards all pending entries
//     bus  - write_buffer_if.slave:
//            in_valid/in_addr/in_block/in_ready  eviction push handshake
//            mem_ready/mem_we/mem_w_addr/mem_block  drain to main memory
//            lk_addr/lk_hit/lk_block  combinational miss-path lookup
//            full/empty/count  occupancy (full feeds memory fifo_full)
module write_buffer #(
    parameter int unsigned BLOCK_SIZE = 256,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DEPTH      = 4
) (
    input  logic           clk,
    input  logic           rst,
    write_buffer_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]      r_valid;
    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [BLOCK_SIZE-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_match;
    logic [PTR_W-1:0]      w_match_idx;
    logic                  w_lk_hit;
    logic [BLOCK_SIZE-1:0] w_lk_block;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_overwrite;
    logic                  w_alloc;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Valid addresses are pairwise distinct, so at most one entry matches
    // each of in_addr and lk_addr.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        w_lk_hit    = 1'b0;
        w_lk_block  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_addr[i] == bus.in_addr)) begin
                w_match     = 1'b1;
                w_match_idx = PTR_W'(i);
            end
            if (r_valid[i] && (r_addr[i] == bus.lk_addr)) begin
                w_lk_hit   = 1'b1;
                w_lk_block = r_data[i];
            end
        end
    end

    assign w_pop  = !w_empty && bus.mem_ready;
    // A full buffer accepts only coalescing pushes. in_ready does not
    // depend on mem_ready.
    assign w_push = bus.in_valid && (!w_full || w_match);
    // If the head matches but is leaving this cycle, the old data still goes
    // out. The new data is queued behind everything else.
    assign w_overwrite = w_push && w_match && !((w_match_idx == r_head) && w_pop);
    assign w_alloc     = w_push && !w_overwrite;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + PTR_W'(1);
            end
            if (w_overwrite) begin
                r_data[w_match_idx] <= bus.in_block;
            end
            // When full, tail equals head. An allocate during a head pop
            // reuses that slot, so this set must come after the pop's clear.
            if (w_alloc) begin
                r_valid[r_tail] <= 1'b1;
                r_addr[r_tail]  <= bus.in_addr;
                r_data[r_tail]  <= bus.in_block;
                r_tail          <= r_tail + PTR_W'(1);
            end
            case ({w_alloc, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready   = !w_full || w_match;
    assign bus.mem_we     = !w_empty;
    assign bus.mem_w_addr = w_empty ? '0 : r_addr[r_head];
    assign bus.mem_block  = w_empty ? '0 : r_data[r_head];
    assign bus.lk_hit     = w_lk_hit;
    assign bus.lk_block   = w_lk_block;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.count      = r_count;
endmodule
